inst_seq_ctrl: RTL and testbench
================================

// Module: inst_seq_ctrl
// PURPOSE
//  Sequencer for the 64-entry instruction buffer (inst_buff). Sits between the host load port and the
//  media-engine datapath. While idle it streams host words into the buffer from address 0 upward.
//  On start it steps a PC through the buffer and issues each instruction to the datapath over a
//  valid/ready handshake. It stops at the halt opcode or at the end of the buffer.
// PARAMETERS
//  INST_WIDTH  25   instruction width; must match inst_buff
//  INST_COUNT  64   buffer depth; PC_W = $clog2(INST_COUNT)
//  HALT_OP     2'b11  value of inst[INST_WIDTH-1 -: 2] that terminates a run; this is inst_buff's reset fill
// PORTS
//  clk               in   1           clock
//  reset             in   1           synchronous, active-high reset
//  load_valid        in   1           host word valid
//  load_data         in   INST_WIDTH  host instruction word
//  load_ready        out  1           word accepted when load_valid & load_ready
//  load_clear        in   1           pulse: rewind load pointer to 0 (IDLE only)
//  start             in   1           pulse: begin run at PC 0 (IDLE only)
//  abort             in   1           pulse: terminate any activity, go IDLE
//  buf_write_en      out  1           to inst_buff write_en
//  buf_write_addr    out  PC_W        to inst_buff buffer_write_addr
//  buf_write_data    out  INST_WIDTH  to inst_buff buffer_write_data
//  buf_addr          out  PC_W        to inst_buff buffer_addr (combinational read)
//  buf_data          in   INST_WIDTH  from inst_buff buffer_out
//  issue_valid       out  1           instruction valid to datapath
//  issue_ready       in   1           datapath accepts
//  issue_inst        out  INST_WIDTH  registered instruction
//  issue_pc          out  PC_W        address of issue_inst
//  busy              out  1           state != IDLE
//  done              out  1           one-cycle pulse when a run ends (halt or end of buffer; not abort)
//  load_count        out  PC_W+1      number of words loaded (0..INST_COUNT)
// BEHAVIOUR
//  Reset: all state and outputs are 0, including load_count and pc. FSM goes to IDLE.
//   Reset mid-run drops issue_valid in the same cycle it is sampled.
//  FSM states: IDLE, FETCH, ISSUE, DONE.
//  IDLE:
//   - load_ready = (load_count < INST_COUNT).
//   - On a load accept, same cycle: buf_write_en=1, buf_write_addr=load_count[PC_W-1:0], buf_write_data=load_data.
//     load_count increments on the next edge.
//   - When load_count = INST_COUNT, load_ready = 0 and no write occurs. load_count does not wrap.
//   - load_clear sets load_count to 0. It wins over a same-cycle load; that load is not written.
//   - start sets pc to 0 and moves to FETCH. start wins over a same-cycle load; load_ready = 0 when start = 1.
//   - start and load_clear together: both take effect.
//  FETCH (1 cycle):
//   - buf_addr = pc; buf_data is captured into issue_inst and pc into issue_pc.
//   - If buf_data[top 2] == HALT_OP, go to DONE; the halt word is never issued. Otherwise go to ISSUE.
//  ISSUE:
//   - issue_valid = 1. issue_inst and issue_pc are held stable until issue_ready.
//   - On handshake: if pc == INST_COUNT-1, go to DONE; else pc increments and FSM goes to FETCH.
//   - Throughput: 1 instruction per 2 cycles with issue_ready tied high.
//  DONE (1 cycle): done = 1, then IDLE. load_count is preserved, so a rerun is possible without reloading.
//  Outside IDLE: load_ready = 0, buf_write_en = 0, start and load_clear are ignored.
//  abort:
//   - In any non-IDLE state, the FSM goes to IDLE on the next edge. issue_valid deasserts that edge
//     even without a handshake (the datapath must tolerate this). No done pulse.
//   - abort in IDLE only blocks a same-cycle start; loads proceed.
//  Priority: reset > abort > start/load_clear > load.
//  buf_addr = pc in all states. Run length is not limited by load_count: unloaded entries hold the
//   reset fill, which is a halt.
// CONFIGURATION
//  INST_SEQ_STEP_EN defined:
//   - Adds input step_mode (1) and input step (1), plus state PAUSE.
//   - With step_mode = 1, every ISSUE handshake that does not end the run enters PAUSE (pc already
//     incremented). The FSM moves to FETCH on the cycle step = 1.
//   - abort leaves PAUSE for IDLE. busy = 1 in PAUSE.
//   - step_mode is sampled at each handshake.
//  INST_SEQ_STEP_EN undefined: the ports and PAUSE state are absent; runs are free-running.
// TESTING
//  1. Load 0x0000001, 0x0000002, 0x0000003 then start, issue_ready=1 -> three issues at pc 0,1,2;
//     pc 3 reads the reset fill 0x1800000 -> done pulse; load_count = 3.
//  2. Load 64 words, none halt -> load_ready = 0 after the 64th and a 65th valid is not written;
//     run issues pc 0..63 then done.
//  3. issue_ready low 5 cycles at pc 1 -> issue_valid, issue_inst, issue_pc stable for 5 cycles;
//     pc 2 follows the handshake.
//  4. abort while waiting in ISSUE at pc 4 -> next cycle busy = 0, issue_valid = 0, no done;
//     restart reissues from pc 0.
//  5. Same-cycle load_valid + load_clear with load_count = 5 -> load_count = 0, buf_write_en = 0;
//     reset mid-run -> all outputs 0 next cycle.
//  6. (INST_SEQ_STEP_EN) step_mode = 1, 3-instruction program -> PAUSE after each issue;
//     each step pulse yields exactly one more issue.

Source files
------------

// File: rtl/inst_seq_ctrl.sv
// Instruction-buffer sequencer: streams host words into inst_buff while idle, then fetches and issues a run from PC 0.
// Defining INST_SEQ_STEP_EN adds step_mode/step inputs and a PAUSE state for single-stepping.
module inst_seq_ctrl #(
    parameter int         INST_WIDTH = 25,
    parameter int         INST_COUNT = 64,
    parameter logic [1:0] HALT_OP    = 2'b11,
    localparam int        PC_W       = $clog2(INST_COUNT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    input  logic [INST_WIDTH-1:0] load_data,
    output logic                  load_ready,
    input  logic                  load_clear,
    input  logic                  start,
    input  logic                  abort,
`ifdef INST_SEQ_STEP_EN
    input  logic                  step_mode,
    input  logic                  step,
`endif
    output logic                  buf_write_en,
    output logic [PC_W-1:0]       buf_write_addr,
    output logic [INST_WIDTH-1:0] buf_write_data,
    output logic [PC_W-1:0]       buf_addr,
    input  logic [INST_WIDTH-1:0] buf_data,
    output logic                  issue_valid,
    input  logic                  issue_ready,
    output logic [INST_WIDTH-1:0] issue_inst,
    output logic [PC_W-1:0]       issue_pc,
    output logic                  busy,
    output logic                  done,
    output logic [PC_W:0]         load_count
);

    localparam logic [PC_W:0]   COUNT_MAX = (PC_W + 1)'(INST_COUNT);
    localparam logic [PC_W-1:0] LAST_PC   = PC_W'(INST_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_DONE
`ifdef INST_SEQ_STEP_EN
        , S_PAUSE
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic [PC_W:0]         load_count_q, load_count_d;
    logic [INST_WIDTH-1:0] issue_inst_q, issue_inst_d;
    logic [PC_W-1:0]       issue_pc_q, issue_pc_d;
    logic                  start_go;
    logic                  load_acc;
    logic                  pause_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            load_count_q <= '0;
            issue_inst_q <= '0;
            issue_pc_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            load_count_q <= load_count_d;
            issue_inst_q <= issue_inst_d;
            issue_pc_q   <= issue_pc_d;
        end
    end

`ifdef INST_SEQ_STEP_EN
    assign pause_req = step_mode;
`else
    assign pause_req = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        load_count_d = load_count_q;
        issue_inst_d = issue_inst_q;
        issue_pc_d   = issue_pc_q;
        load_ready   = 1'b0;
        load_acc     = 1'b0;
        issue_valid  = 1'b0;
        done         = 1'b0;
        // abort in IDLE only suppresses start; loading carries on
        start_go     = start && !abort;

        case (state_q)
            S_IDLE: begin
                load_ready = (load_count_q < COUNT_MAX) && !load_clear && !start_go;
                load_acc   = load_valid && load_ready;
                if (load_acc)
                    load_count_d = load_count_q + (PC_W + 1)'(1);
                if (load_clear)
                    load_count_d = '0;
                if (start_go) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                issue_inst_d = buf_data;
                issue_pc_d   = pc_q;
                state_d = (buf_data[INST_WIDTH-1 -: 2] == HALT_OP) ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                issue_valid = 1'b1;
                if (issue_ready) begin
                    if (pc_q == LAST_PC) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc_q + PC_W'(1);
                        state_d = pause_req ? state_t'(3'd4) : S_FETCH;
                    end
                end
            end
            S_DONE: begin
                done    = !abort;
                state_d = S_IDLE;
            end
`ifdef INST_SEQ_STEP_EN
            S_PAUSE: begin
                if (step)
                    state_d = S_FETCH;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (abort && state_q != S_IDLE)
            state_d = S_IDLE;

        // Reset silences handshake outputs in the cycle it is sampled
        if (reset) begin
            load_ready  = 1'b0;
            load_acc    = 1'b0;
            issue_valid = 1'b0;
            done        = 1'b0;
        end
    end

    assign buf_write_en   = load_acc;
    assign buf_write_addr = load_acc ? load_count_q[PC_W-1:0] : '0;
    assign buf_write_data = load_acc ? load_data : '0;
    assign buf_addr       = pc_q;
    assign issue_inst     = issue_inst_q;
    assign issue_pc       = issue_pc_q;
    assign busy           = (state_q != S_IDLE);
    assign load_count     = load_count_q;

endmodule

// File: tb/tb_inst_seq_ctrl.sv
// Self-checking bench for inst_seq_ctrl: models inst_buff, drives table vectors, directed corner runs and random runs.
module tb_inst_seq_ctrl;

    localparam int          W    = 25;
    localparam int          N    = 64;
    localparam logic [24:0] FILL = 25'h1800000;

    logic          clk = 1'b0;
    logic          reset, load_valid, load_ready, load_clear, start, abort;
    logic [W-1:0]  load_data, buf_write_data, buf_data, issue_inst;
    logic          buf_write_en, issue_valid, issue_ready, busy, done;
    logic [5:0]    buf_write_addr, buf_addr, issue_pc;
    logic [6:0]    load_count;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mem [N];
    logic [W-1:0] model_mem [N];
    int           model_count;
    int           exp_pc [$];
    logic [W-1:0] exp_inst [$];

    always #5 clk = ~clk;

    inst_seq_ctrl dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .load_clear(load_clear), .start(start), .abort(abort),
        .buf_write_en(buf_write_en), .buf_write_addr(buf_write_addr),
        .buf_write_data(buf_write_data), .buf_addr(buf_addr), .buf_data(buf_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_inst(issue_inst), .issue_pc(issue_pc),
        .busy(busy), .done(done), .load_count(load_count)
    );

    // inst_buff model: reset fills with halt, synchronous write, combinational read
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) mem[i] <= FILL;
        end else if (buf_write_en) begin
            mem[buf_write_addr] <= buf_write_data;
        end
    end
    assign buf_data = mem[buf_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(issue_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(load_ready), 32'd0);
        check("rst_wen", 32'(buf_write_en), 32'd0);
        check("rst_count", 32'(load_count), 32'd0);
        check("rst_pc", 32'(issue_pc), 32'd0);
        check("rst_inst", 32'(issue_inst), 32'd0);
        check("rst_bufaddr", 32'(buf_addr), 32'd0);
        tick();
        reset = 1'b0;
        model_count = 0;
        for (int i = 0; i < N; i++) model_mem[i] = FILL;
    endtask

    task automatic load_word(input logic lv, input logic [W-1:0] w);
        logic acc;
        acc = lv && (model_count < N);
        load_valid = lv;
        load_data  = w;
        #1;
        check("load_ready", 32'(load_ready), 32'(model_count < N));
        check("load_wen", 32'(buf_write_en), 32'(acc));
        if (acc) check("load_addr", 32'(buf_write_addr), 32'(model_count % N));
        tick();
        load_valid = 1'b0;
        if (acc) begin
            model_mem[model_count] = w;
            model_count++;
        end
        check("load_count", 32'(load_count), 32'(model_count));
    endtask

    task automatic clear_loads();
        load_clear = 1'b1;
        tick();
        load_clear = 1'b0;
        model_count = 0;
        check("clear_count", 32'(load_count), 32'd0);
    endtask

    // Expected run: walk the buffer from 0 until a halt word or the last entry
    task automatic build_expect();
        exp_pc.delete();
        exp_inst.delete();
        for (int p = 0; p < N; p++) begin
            if (model_mem[p][W-1 -: 2] == 2'b11) break;
            exp_pc.push_back(p);
            exp_inst.push_back(model_mem[p]);
        end
    endtask

    task automatic run(input int ready_pct, input int abort_after, input logic with_clear, input string tag);
        int  idx;
        bit  seen_done, aborted;
        int  done_cyc;
        build_expect();
        idx = 0; seen_done = 0; aborted = 0; done_cyc = -1;
        start = 1'b1; load_valid = 1'b1; load_data = 25'h0ABCDE; load_clear = with_clear;
        #1;
        check({tag, "_start_ready"}, 32'(load_ready), 32'd0);
        check({tag, "_start_wen"}, 32'(buf_write_en), 32'd0);
        tick();
        start = 1'b0; load_valid = 1'b0; load_clear = 1'b0;
        if (with_clear) model_count = 0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_count_kept"}, 32'(load_count), 32'(model_count));
        for (int cyc = 0; cyc < 600 && !seen_done; cyc++) begin
            issue_ready = ($urandom_range(99) < ready_pct);
            if (abort_after >= 0 && idx == abort_after && issue_valid) begin
                abort = 1'b1;
                issue_ready = 1'b0;
            end
            #1;
            if (abort) begin
                tick();
                abort = 1'b0;
                #1;
                check({tag, "_abort_busy"}, 32'(busy), 32'd0);
                check({tag, "_abort_valid"}, 32'(issue_valid), 32'd0);
                check({tag, "_abort_done"}, 32'(done), 32'd0);
                aborted = 1;
                break;
            end
            if (issue_valid && issue_ready) begin
                if (idx < exp_pc.size()) begin
                    check({tag, "_pc"}, 32'(issue_pc), 32'(exp_pc[idx]));
                    check({tag, "_inst"}, 32'(issue_inst), 32'(exp_inst[idx]));
                end else begin
                    check({tag, "_extra_issue"}, 32'(idx), 32'(exp_pc.size()));
                end
                idx++;
            end
            if (done) begin
                seen_done = 1;
                done_cyc = cyc;
                check({tag, "_issue_count"}, 32'(idx), 32'(exp_pc.size()));
            end
            tick();
        end
        issue_ready = 1'b0;
        check({tag, "_terminated"}, 32'(seen_done || aborted), 32'd1);
        if (seen_done) begin
            check({tag, "_idle_after"}, 32'(busy), 32'd0);
            if (ready_pct >= 100)
                check({tag, "_cycles"}, 32'(done_cyc),
                      32'((exp_pc.size() == N) ? 2 * N : 2 * exp_pc.size() + 1));
        end
    endtask

    typedef struct {
        logic lv, lc, st, ab;
        logic exp_ready, exp_wen;
        int   exp_count;
    } vec_t;

    initial begin
        vec_t vecs [8];
        bit   found;
        logic [W-1:0] w;

        reset = 1'b1; load_valid = 0; load_data = '0; load_clear = 0;
        start = 0; abort = 0; issue_ready = 0;
        do_reset();

        vecs[0] = '{1, 0, 0, 0, 1, 1, 1};
        vecs[1] = '{1, 0, 0, 0, 1, 1, 2};
        vecs[2] = '{0, 0, 0, 0, 1, 0, 2};
        vecs[3] = '{1, 0, 0, 1, 1, 1, 3};
        vecs[4] = '{1, 0, 1, 1, 1, 1, 4};
        vecs[5] = '{1, 1, 0, 0, 0, 0, 0};
        vecs[6] = '{1, 0, 0, 0, 1, 1, 1};
        vecs[7] = '{0, 1, 0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            load_valid = vecs[i].lv; load_clear = vecs[i].lc;
            start = vecs[i].st; abort = vecs[i].ab; load_data = 25'(32'h100 + i);
            #1;
            check($sformatf("vec%0d_ready", i), 32'(load_ready), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d_wen", i), 32'(buf_write_en), 32'(vecs[i].exp_wen));
            if (vecs[i].exp_wen)
                check($sformatf("vec%0d_addr", i), 32'(buf_write_addr), 32'(model_count));
            tick();
            if (vecs[i].exp_wen) model_mem[model_count] = load_data;
            model_count = vecs[i].exp_count;
            load_valid = 0; load_clear = 0; start = 0; abort = 0;
            check($sformatf("vec%0d_count", i), 32'(load_count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
        end

        // three words then reset-fill halt
        do_reset();
        load_word(1, 25'h0000001);
        load_word(1, 25'h0000002);
        load_word(1, 25'h0000003);
        run(100, -1, 0, "t1");
        check("t1_count", 32'(load_count), 32'd3);

        // full buffer, no halt; 65th word rejected
        clear_loads();
        for (int i = 0; i < N; i++) load_word(1, 25'(32'h0400000 + i * 3));
        load_word(1, 25'h0123456);
        run(100, -1, 0, "t2");

        // stall at pc 1
        start = 1; tick(); start = 0; issue_ready = 1; found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            #1;
            if (issue_valid && issue_pc == 6'd1) begin
                issue_ready = 0;
                found = 1;
            end else begin
                tick();
            end
        end
        check("t3_reach_pc1", 32'(found), 32'd1);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t3_hold_valid", 32'(issue_valid), 32'd1);
            check("t3_hold_pc", 32'(issue_pc), 32'd1);
            check("t3_hold_inst", 32'(issue_inst), 32'(model_mem[1]));
            tick();
        end
        issue_ready = 1;
        #1;
        check("t3_hs_valid", 32'(issue_valid), 32'd1);
        tick();
        tick();
        issue_ready = 0;
        check("t3_next_pc", 32'(issue_pc), 32'd2);
        check("t3_next_inst", 32'(issue_inst), 32'(model_mem[2]));
        check("t3_next_valid", 32'(issue_valid), 32'd1);
        abort = 1; tick(); abort = 0;
        check("t3_abort_idle", 32'(busy), 32'd0);

        // abort waiting at pc 4, then restart from 0; start+clear together
        run(50, 4, 0, "t4a");
        run(100, -1, 1, "t4b");

        // clear beats load at count 5; reset mid-run
        for (int i = 0; i < 5; i++) load_word(1, 25'(32'h0200000 + i));
        load_valid = 1; load_clear = 1; load_data = 25'h0000077;
        #1;
        check("t5_clr_wen", 32'(buf_write_en), 32'd0);
        tick();
        load_valid = 0; load_clear = 0; model_count = 0;
        check("t5_clr_count", 32'(load_count), 32'd0);
        start = 1; tick(); start = 0;
        tick(); tick();
        check("t5_run_valid", 32'(issue_valid), 32'd1);
        reset = 1;
        #1;
        check("t5_rst_valid_now", 32'(issue_valid), 32'd0);
        do_reset();

        // randomized runs against the buffer-walk model
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(2) == 0) clear_loads();
            for (int j = 0; j < int'($urandom_range(12)); j++) begin
                w = 25'($urandom);
                w[W-1 -: 2] = ($urandom_range(15) == 0) ? 2'b11 : 2'($urandom_range(2));
                load_word(1'($urandom_range(4) != 0), w);
            end
            run(int'($urandom_range(30, 100)),
                ($urandom_range(3) == 0) ? int'($urandom_range(5)) : -1,
                1'b0, $sformatf("rnd%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
